// File: rtl/risc_pkg.sv
// Shared definitions for the RISC program loader: loader states, the default
// frame sync marker and the instruction word width.
package risc_pkg;

    localparam int         INSTR_W           = 16;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA_HI,
        DATA_LO,
        CHECK,
        DONE,
        ERR
    } state_t;

    // Every state consumes a byte per cycle; the terminal states still watch
    // for the sync marker so a new program can be loaded without a reset.
    function automatic logic accepts_byte(input state_t s);
        case (s)
            IDLE, COUNT, DATA_HI, DATA_LO, CHECK, DONE, ERR: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/frame_chk_xor.sv
// Running XOR over the data bytes of one frame; cleared when a new frame
// starts so the accumulator only ever covers the current program image.
module frame_chk_xor (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_en,
    input  logic [7:0] i_data,
    output logic [7:0] o_acc
);

    logic [7:0] r_acc;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_acc <= 8'h00;
        end else if (i_en) begin
            r_acc <= r_acc ^ i_data;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/risc_prog_loader.sv
// Framed byte-stream loader for the 16-bit RISC core: assembles instruction
// words, writes them to instruction memory and releases the core on a good load.
module risc_prog_loader
    import risc_pkg::*;
#(
    parameter int         ADDR_W    = 4,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               core_hold,
    output logic               done,
    output logic               error,
    output logic [ADDR_W:0]    words_loaded
);

    localparam int          CNT_W    = ADDR_W + 1;
    localparam int unsigned CAPACITY = 1 << ADDR_W;

    state_t               r_state;
    logic [7:0]           r_hi;
    logic [CNT_W-1:0]     r_n;
    logic [CNT_W-1:0]     r_words;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_addr;
    logic [INSTR_W-1:0]   r_wdata;
    logic                 r_hold;
    logic                 r_done;
    logic                 r_error;

    logic                 w_xfer;
    logic                 w_sync;
    logic                 w_chk_en;
    logic [7:0]           w_chk_acc;
    logic [CNT_W-1:0]     w_words_next;

    assign in_ready     = accepts_byte(r_state);
    assign w_xfer       = in_valid & in_ready;
    assign w_sync       = w_xfer && (in_data == SYNC_BYTE)
                          && (r_state inside {IDLE, DONE, ERR});
    assign w_chk_en     = w_xfer && (r_state inside {DATA_HI, DATA_LO});
    assign w_words_next = r_words + CNT_W'(1);

    frame_chk_xor u_chk (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_sync),
        .i_en    (w_chk_en),
        .i_data  (in_data),
        .o_acc   (w_chk_acc)
    );

    // NOTE: every register here is assigned with <= so all branches see the
    // pre-edge values; the datapath registers are reset too, so imem_addr and
    // imem_wdata come out of reset at zero rather than X.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_hi    <= 8'h00;
            r_n     <= '0;
            r_words <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_xfer) begin
                unique case (r_state)
                    IDLE, DONE, ERR: begin
                        if (in_data == SYNC_BYTE) begin
                            r_state <= COUNT;
                            r_done  <= 1'b0;
                            r_error <= 1'b0;
                            r_words <= '0;
                            r_addr  <= '0;
                            r_hold  <= 1'b1;
                        end
                    end
                    COUNT: begin
                        if (in_data == 8'h00 || 32'(in_data) > CAPACITY) begin
                            r_state <= ERR;
                            r_error <= 1'b1;
                        end else begin
                            r_n     <= CNT_W'(in_data);
                            r_state <= DATA_HI;
                        end
                    end
                    DATA_HI: begin
                        r_hi    <= in_data;
                        r_state <= DATA_LO;
                    end
                    DATA_LO: begin
                        // The word count doubles as the write address; N never
                        // exceeds capacity, so the truncation cannot alias.
                        r_we    <= 1'b1;
                        r_wdata <= {r_hi, in_data};
                        r_addr  <= r_words[ADDR_W-1:0];
                        r_words <= w_words_next;
                        r_state <= (w_words_next == r_n) ? CHECK : DATA_HI;
                    end
                    CHECK: begin
                        if (in_data == w_chk_acc) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_hold  <= 1'b0;
                        end else begin
                            r_state <= ERR;
                            r_error <= 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign core_hold    = r_hold;
    assign done         = r_done;
    assign error        = r_error;
    assign words_loaded = r_words;

endmodule
